// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative right shifter.
// FSM state encoding, default widths, and fill-mode op encoding.
package shift_pkg;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    FILL_ZERO = 1'b0,
    FILL_SIGN = 1'b1
  } fill_t;

endpackage

// File: rtl/srl_step.sv
// One conditional right shift by 2^k with a fill bit (combinational).
// Ports: d in, k step index, en apply, fill vacated-bit value, q out.
module srl_step #(
  parameter int WIDTH = 16,
  parameter int SHW   = 5,
  parameter int CW    = 2
) (
  input  logic [WIDTH-1:0] d,
  input  logic [CW-1:0]    k,
  input  logic             en,
  input  logic             fill,
  output logic [WIDTH-1:0] q
);

  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] fmask;

  assign amt   = {{(SHW-1){1'b0}}, 1'b1} << k;
  assign ones  = '1;
  assign sh    = d >> amt;
  assign fmask = ~(ones >> amt);
  assign q     = en ? (sh | (fill ? fmask : '0)) : d;

endmodule

// File: rtl/srl_iter.sv
// Multi-cycle right shifter, one shamt bit per cycle; valid/ready in and out.
// Ports: clk, rst_n (sync, low), in_valid/in_ready, ain, shamt, arith,
//   out_valid/out_ready, aout, busy. SRL_ITER_SRA_EN enables sign fill.
module srl_iter
  import shift_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SHW   = SHAMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aout,
  output logic             busy
);

  localparam int CW = $clog2(SHW-1);
  localparam logic [CW-1:0] LAST = CW'(SHW-2);

`ifdef SRL_ITER_SRA_EN
  localparam logic SRA_EN = 1'b1;
`else
  localparam logic SRA_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  fill_t            op_q, op_d;
  logic [SHW-2:0]   sham_q, sham_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic [WIDTH-1:0] res_q, res_d;

  fill_t            cap_op;
  logic             cap_fill;
  logic             step_fill;
  logic [WIDTH-1:0] step_q;

  assign cap_op    = (SRA_EN && arith) ? FILL_SIGN : FILL_ZERO;
  assign cap_fill  = (cap_op == FILL_SIGN) & ain[WIDTH-1];
  // SRA fills from the current MSB, which equals the original sign.
  assign step_fill = (op_q == FILL_SIGN) & reg_q[WIDTH-1];

  srl_step #(
    .WIDTH (WIDTH),
    .SHW   (SHW),
    .CW    (CW)
  ) u_step (
    .d    (reg_q),
    .k    (cnt_q),
    .en   (sham_q[cnt_q]),
    .fill (step_fill),
    .q    (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= FILL_ZERO;
      sham_q  <= '0;
      reg_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sham_q  <= sham_d;
      reg_q   <= reg_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sham_d  = sham_q;
    reg_d   = reg_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          cnt_d   = '0;
          op_d    = cap_op;
          sham_d  = shamt[SHW-2:0];
          // shamt >= WIDTH saturates straight to the fill word.
          reg_d   = shamt[SHW-1] ? {WIDTH{cap_fill}} : ain;
        end
      end
      SHIFT: begin
        reg_d = step_q;
        if (cnt_q == LAST) begin
          state_d = DONE;
          res_d   = step_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign aout      = res_q;

endmodule

// File: tb/tb_srl_iter.sv
// Directed table-driven bench for srl_iter.
// Checks results, fixed latency, hold, ignored inputs and mid-op reset.
module tb_srl_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ain;
  logic [4:0]  shamt;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] aout;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  srl_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ain       (ain),
    .shamt     (shamt),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .aout      (aout),
    .busy      (busy)
  );

  typedef struct {
    logic [15:0] a;
    logic [4:0]  s;
    logic        ar;
    logic [15:0] srl;
    logic [15:0] sra;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pick(input vec_t v);
`ifdef SRL_ITER_SRA_EN
    return v.ar ? v.sra : v.srl;
`else
    return v.srl;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch an op and wait (bounded) for out_valid; lat counts edges.
  task automatic run_op(input logic [15:0] a, input logic [4:0] s,
                        input logic ar, output logic [15:0] res,
                        output int lat);
    ain      = a;
    shamt    = s;
    arith    = ar;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    res = aout;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
  endtask

  logic [15:0] r;
  int          l;
  logic [15:0] held;

  initial begin
    tbl[0] = '{16'h8000, 5'd4,  1'b0, 16'h0800, 16'h0800};
    tbl[1] = '{16'h8000, 5'd4,  1'b1, 16'h0800, 16'hF800};
    tbl[2] = '{16'h1234, 5'd0,  1'b0, 16'h1234, 16'h1234};
    tbl[3] = '{16'h8001, 5'd16, 1'b1, 16'h0000, 16'hFFFF};
    tbl[4] = '{16'h8001, 5'd16, 1'b0, 16'h0000, 16'h0000};
    tbl[5] = '{16'hF0F0, 5'd15, 1'b0, 16'h0001, 16'h0001};
    tbl[6] = '{16'h8421, 5'd5,  1'b1, 16'h0421, 16'hFC21};
    tbl[7] = '{16'h7FFF, 5'd31, 1'b1, 16'h0000, 16'h0000};
    tbl[8] = '{16'h8000, 5'd15, 1'b1, 16'h0001, 16'hFFFF};
    tbl[9] = '{16'hA5A5, 5'd1,  1'b1, 16'h52D2, 16'hD2D2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    ain       = '0;
    shamt     = '0;
    arith     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst aout", 32'(aout), 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b1;
      run_op(tbl[i].a, tbl[i].s, tbl[i].ar, r, l);
      chk($sformatf("vec%0d aout", i), 32'(r), 32'(pick(tbl[i])));
      chk($sformatf("vec%0d lat", i), 32'(l), 32'd4);
      accept();
      chk($sformatf("vec%0d idle", i), 32'(in_ready), 32'd1);
    end

    // Backpressure: result held stable while out_ready is low.
    out_ready = 1'b0;
    run_op(16'hF0F0, 5'd15, 1'b0, r, l);
    chk("hold aout", 32'(r), 32'h0001);
    chk("hold lat", 32'(l), 32'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold valid", 32'(out_valid), 32'd1);
      chk("hold data", 32'(aout), 32'h0001);
      chk("hold in_ready", 32'(in_ready), 32'd0);
    end
    accept();
    chk("hold rel valid", 32'(out_valid), 32'd0);
    chk("hold rel in_ready", 32'(in_ready), 32'd1);
    chk("hold rel aout", 32'(aout), 32'h0001);

    // Second op offered during SHIFT and DONE is ignored.
    out_ready = 1'b0;
    ain      = 16'h8000;
    shamt    = 5'd4;
    arith    = 1'b0;
    in_valid = 1'b1;
    tick();
    ain      = 16'h1234;
    shamt    = 5'd1;
    tick();
    chk("ign busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 20) begin
      tick();
      l++;
    end
    chk("ign lat", 32'(l), 32'd4);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ign done aout", 32'(aout), 32'h0800);
    chk("ign done valid", 32'(out_valid), 32'd1);
    accept();
    out_ready = 1'b1;
    held = aout;
    for (int i = 0; i < 7; i++) tick();
    chk("ign no queue", 32'(busy), 32'd0);
    chk("ign no valid", 32'(out_valid), 32'd0);
    chk("ign keep aout", 32'(held), 32'h0800);

    // Reset during the second SHIFT cycle drops the op.
    ain      = 16'hFFFF;
    shamt    = 5'd2;
    arith    = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst busy", 32'(busy), 32'd0);
    chk("mrst out_valid", 32'(out_valid), 32'd0);
    chk("mrst in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst stays idle", 32'(out_valid), 32'd0);
    end
    run_op(16'h8421, 5'd5, 1'b1, r, l);
    chk("mrst new aout", 32'(r), 32'(pick(tbl[6])));
    chk("mrst new lat", 32'(l), 32'd4);
    accept();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
